// File: rtl/acc_req_rr_arbiter.sv
// rtl/acc_req_rr_arbiter.sv - round-robin C-bus request arbiter with ID extension and response routing
module acc_req_rr_arbiter #(
    parameter int NumReq         = 8,
    parameter int AddrWidth      = 6,
    parameter int DataWidth      = 32,
    parameter int IdWidth        = 1,
    parameter int MaxOutstanding = 4,
    localparam int ExtIdWidth    = IdWidth + $clog2(NumReq)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq*DataWidth-1:0]    req_data_i,
    input  logic [NumReq*IdWidth-1:0]      req_id_i,
    output logic                           mst_req_valid_o,
    input  logic                           mst_req_ready_i,
    output logic [AddrWidth-1:0]           mst_req_addr_o,
    output logic [DataWidth-1:0]           mst_req_data_o,
    output logic [ExtIdWidth-1:0]          mst_req_id_o,
    input  logic                           mst_rsp_valid_i,
    output logic                           mst_rsp_ready_o,
    input  logic [DataWidth-1:0]           mst_rsp_data_i,
    input  logic [ExtIdWidth-1:0]          mst_rsp_id_i,
    output logic [NumReq-1:0]              rsp_valid_o,
    input  logic [NumReq-1:0]              rsp_ready_i,
    output logic [NumReq*DataWidth-1:0]    rsp_data_o,
    output logic [NumReq*IdWidth-1:0]      rsp_id_o,
    output logic                           rsp_err_o
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [CntW-1:0]      cnt [NumReq];
    logic [IdxW-1:0]      ptr;
    logic [NumReq-1:0]    eligible;
    logic [NumReq-1:0]    inc;
    logic [NumReq-1:0]    dec;
    logic                 any_all;
    logic                 any_hi;
    logic [IdxW-1:0]      low_all;
    logic [IdxW-1:0]      low_hi;
    logic [IdxW-1:0]      winner;
    logic                 take;
    logic                 grant;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_data;
    logic [IdWidth-1:0]   sel_id;
    logic [IdxW-1:0]      rsp_idx;
    logic                 idx_ok;
    logic                 route_ready;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt[i] < CntW'(MaxOutstanding));
        end
    end

    // Lowest eligible index at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        any_all = 1'b0;
        any_hi  = 1'b0;
        low_all = '0;
        low_hi  = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any_all = 1'b1;
                low_all = IdxW'(i);
            end
            if (eligible[i] && (i >= int'(ptr))) begin
                any_hi = 1'b1;
                low_hi = IdxW'(i);
            end
        end
        winner = any_hi ? low_hi : low_all;
    end

    assign take  = !mst_req_valid_o || mst_req_ready_i;
    assign grant = take && any_all;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = grant && (winner == IdxW'(i));
            inc[i]         = req_ready_o[i];
            if (winner == IdxW'(i)) begin
                sel_addr = req_addr_i[i*AddrWidth +: AddrWidth];
                sel_data = req_data_i[i*DataWidth +: DataWidth];
                sel_id   = req_id_i[i*IdWidth +: IdWidth];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mst_req_valid_o <= 1'b0;
            mst_req_addr_o  <= '0;
            mst_req_data_o  <= '0;
            mst_req_id_o    <= '0;
            ptr             <= '0;
        end else begin
            if (grant) begin
                mst_req_valid_o <= 1'b1;
                mst_req_addr_o  <= sel_addr;
                mst_req_data_o  <= sel_data;
                mst_req_id_o    <= {winner, sel_id};
                ptr             <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
            end else if (mst_req_ready_i) begin
                mst_req_valid_o <= 1'b0;
            end
        end
    end

    // A response only routes when its index exists and that requester has something outstanding.
    assign rsp_idx = mst_rsp_id_i[ExtIdWidth-1:IdWidth];

    always_comb begin
        idx_ok      = 1'b0;
        route_ready = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if ((rsp_idx == IdxW'(i)) && (cnt[i] != '0)) begin
                idx_ok      = 1'b1;
                route_ready = rsp_ready_i[i];
            end
        end
    end

    assign mst_rsp_ready_o = idx_ok ? route_ready : 1'b1;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            rsp_valid_o[i] = mst_rsp_valid_i && idx_ok && (rsp_idx == IdxW'(i));
            dec[i]         = rsp_valid_o[i] && rsp_ready_i[i];
        end
    end

    assign rsp_data_o = {NumReq{mst_rsp_data_i}};
    assign rsp_id_o   = {NumReq{mst_rsp_id_i[IdWidth-1:0]}};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rsp_err_o <= 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rsp_err_o <= mst_rsp_valid_i && !idx_ok;
            for (int i = 0; i < NumReq; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + CntW'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CntW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_acc_req_rr_arbiter.sv
// tb/tb_acc_req_rr_arbiter.sv - directed self-checking bench for acc_req_rr_arbiter
module tb_acc_req_rr_arbiter;
    localparam int NumReq = 8;
    localparam int AddrWidth = 6;
    localparam int DataWidth = 32;
    localparam int IdWidth = 1;
    localparam int ExtIdWidth = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq*AddrWidth-1:0] req_addr_i;
    logic [NumReq*DataWidth-1:0] req_data_i;
    logic [NumReq*IdWidth-1:0]   req_id_i;
    logic                        mst_req_valid_o;
    logic                        mst_req_ready_i;
    logic [AddrWidth-1:0]        mst_req_addr_o;
    logic [DataWidth-1:0]        mst_req_data_o;
    logic [ExtIdWidth-1:0]       mst_req_id_o;
    logic                        mst_rsp_valid_i;
    logic                        mst_rsp_ready_o;
    logic [DataWidth-1:0]        mst_rsp_data_i;
    logic [ExtIdWidth-1:0]       mst_rsp_id_i;
    logic [NumReq-1:0]           rsp_valid_o;
    logic [NumReq-1:0]           rsp_ready_i;
    logic [NumReq*DataWidth-1:0] rsp_data_o;
    logic [NumReq*IdWidth-1:0]   rsp_id_o;
    logic                        rsp_err_o;

    int vectors = 0;
    int miscompares = 0;

    acc_req_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_id_i(req_id_i),
        .mst_req_valid_o(mst_req_valid_o), .mst_req_ready_i(mst_req_ready_i),
        .mst_req_addr_o(mst_req_addr_o), .mst_req_data_o(mst_req_data_o),
        .mst_req_id_o(mst_req_id_o),
        .mst_rsp_valid_i(mst_rsp_valid_i), .mst_rsp_ready_o(mst_rsp_ready_o),
        .mst_rsp_data_i(mst_rsp_data_i), .mst_rsp_id_i(mst_rsp_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        req_valid_i = '0;
        mst_req_ready_i = 1'b0;
        mst_rsp_valid_i = 1'b0;
        mst_rsp_data_i = '0;
        mst_rsp_id_i = '0;
        rsp_ready_i = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_addr_i[i*AddrWidth +: AddrWidth] = AddrWidth'(i + 10);
            req_data_i[i*DataWidth +: DataWidth] = 32'hA000_0000 + i;
            req_id_i[i*IdWidth +: IdWidth] = IdWidth'(i & 1);
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        vectors++;
        if (mst_req_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 0", mst_req_valid_o);
        end
        vectors++;
        if (req_ready_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ready got %h want 00", req_ready_o);
        end
        vectors++;
        if (rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err got %b want 0", rsp_err_o);
        end
        vectors++;
        if (mst_req_id_o !== 4'h0 || mst_req_addr_o !== 6'h0) begin
            miscompares++;
            $display("FAIL reset_regs got id %h addr %h want 0 0", mst_req_id_o, mst_req_addr_o);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_ready [6] = '{8'h01, 8'h08, 8'h20, 8'h01, 8'h08, 8'h20};
        logic [3:0] exp_id [6] = '{4'd0, 4'd7, 4'd11, 4'd0, 4'd7, 4'd11};
        logic [5:0] exp_addr [6] = '{6'd10, 6'd13, 6'd15, 6'd10, 6'd13, 6'd15};
        do_reset();
        req_valid_i = 8'b0010_1001;
        mst_req_ready_i = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (req_ready_o !== exp_ready[k]) begin
                miscompares++;
                $display("FAIL fair_grant k=%0d got %h want %h", k, req_ready_o, exp_ready[k]);
            end
            tick();
            vectors++;
            if (mst_req_valid_o !== 1'b1 || mst_req_id_o !== exp_id[k] || mst_req_addr_o !== exp_addr[k]) begin
                miscompares++;
                $display("FAIL fair_out k=%0d got v%b id %h addr %h want v1 id %h addr %h",
                         k, mst_req_valid_o, mst_req_id_o, mst_req_addr_o, exp_id[k], exp_addr[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid_i = 8'h04;
        #1;
        vectors++;
        if (req_ready_o !== 8'h04) begin
            miscompares++;
            $display("FAIL bp_first got %h want 04", req_ready_o);
        end
        tick();
        req_addr_i[2*AddrWidth +: AddrWidth] = 6'd20;
        req_data_i[2*DataWidth +: DataWidth] = 32'h1234_5678;
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (req_ready_o !== 8'h00 || mst_req_valid_o !== 1'b1 || mst_req_addr_o !== 6'd12
                || mst_req_data_o !== 32'hA000_0002 || mst_req_id_o !== 4'd4) begin
                miscompares++;
                $display("FAIL bp_hold k=%0d got rdy %h v%b addr %h data %h id %h want 00 v1 0c a0000002 4",
                         k, req_ready_o, mst_req_valid_o, mst_req_addr_o, mst_req_data_o, mst_req_id_o);
            end
            tick();
        end
        mst_req_ready_i = 1'b1;
        #1;
        vectors++;
        if (req_ready_o !== 8'h04) begin
            miscompares++;
            $display("FAIL bp_refill_grant got %h want 04", req_ready_o);
        end
        tick();
        vectors++;
        if (mst_req_valid_o !== 1'b1 || mst_req_addr_o !== 6'd20 || mst_req_data_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL bp_refill_out got v%b addr %h data %h want v1 14 12345678",
                     mst_req_valid_o, mst_req_addr_o, mst_req_data_o);
        end
    endtask

    task automatic test_outstanding();
        do_reset();
        req_valid_i = 8'h02;
        mst_req_ready_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (req_ready_o !== 8'h02) begin
                miscompares++;
                $display("FAIL lim_grant k=%0d got %h want 02", k, req_ready_o);
            end
            tick();
        end
        req_valid_i = 8'h42;
        #1;
        vectors++;
        if (req_ready_o !== 8'h40) begin
            miscompares++;
            $display("FAIL lim_other got %h want 40", req_ready_o);
        end
        tick();
        req_valid_i = 8'h02;
        mst_rsp_valid_i = 1'b1;
        mst_rsp_id_i = 4'b0010;
        rsp_ready_i = 8'h02;
        #1;
        vectors++;
        if (req_ready_o !== 8'h00 || rsp_valid_o !== 8'h02 || mst_rsp_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL lim_blocked got rdy %h rspv %h mrdy %b want 00 02 1",
                     req_ready_o, rsp_valid_o, mst_rsp_ready_o);
        end
        tick();
        mst_rsp_valid_i = 1'b0;
        #1;
        vectors++;
        if (req_ready_o !== 8'h02) begin
            miscompares++;
            $display("FAIL lim_release got %h want 02", req_ready_o);
        end
    endtask

    task automatic test_rsp_routing();
        do_reset();
        req_valid_i = 8'h10;
        mst_req_ready_i = 1'b1;
        tick();
        req_valid_i = 8'h00;
        mst_rsp_valid_i = 1'b1;
        mst_rsp_id_i = 4'b1001;
        mst_rsp_data_i = 32'hDEAD_BEEF;
        rsp_ready_i = 8'h00;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (rsp_valid_o !== 8'h10 || mst_rsp_ready_o !== 1'b0 || rsp_data_o[4*DataWidth +: DataWidth] !== 32'hDEAD_BEEF
                || rsp_id_o[4*IdWidth +: IdWidth] !== 1'b1) begin
                miscompares++;
                $display("FAIL route_hold k=%0d got v %h rdy %b data %h id %b want 10 0 deadbeef 1", k,
                         rsp_valid_o, mst_rsp_ready_o, rsp_data_o[4*DataWidth +: DataWidth], rsp_id_o[4*IdWidth +: IdWidth]);
            end
            tick();
        end
        rsp_ready_i = 8'h10;
        #1;
        vectors++;
        if (mst_rsp_ready_o !== 1'b1 || rsp_valid_o !== 8'h10) begin
            miscompares++;
            $display("FAIL route_hs got rdy %b v %h want 1 10", mst_rsp_ready_o, rsp_valid_o);
        end
        tick();
        #1;
        vectors++;
        if (rsp_valid_o !== 8'h00 || mst_rsp_ready_o !== 1'b1 || rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL route_drained got v %h rdy %b err %b want 00 1 0", rsp_valid_o, mst_rsp_ready_o, rsp_err_o);
        end
        tick();
        mst_rsp_valid_i = 1'b0;
        #1;
        vectors++;
        if (rsp_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL route_unmatched_err got %b want 1", rsp_err_o);
        end
    endtask

    task automatic test_invalid_rsp();
        do_reset();
        mst_rsp_valid_i = 1'b1;
        mst_rsp_id_i = 4'b1110;
        rsp_ready_i = 8'h00;
        #1;
        vectors++;
        if (mst_rsp_ready_o !== 1'b1 || rsp_valid_o !== 8'h00 || rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_comb got rdy %b v %h err %b want 1 00 0", mst_rsp_ready_o, rsp_valid_o, rsp_err_o);
        end
        tick();
        mst_rsp_valid_i = 1'b0;
        #1;
        vectors++;
        if (rsp_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_err_pulse got %b want 1", rsp_err_o);
        end
        tick();
        vectors++;
        if (rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_err_clear got %b want 0", rsp_err_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid_i = 8'h08;
        tick();
        req_valid_i = 8'h00;
        #1;
        vectors++;
        if (mst_req_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre got %b want 1", mst_req_valid_o);
        end
        #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (mst_req_valid_o !== 1'b0 || mst_req_id_o !== 4'h0) begin
            miscompares++;
            $display("FAIL areset_drop got v%b id %h want 0 0", mst_req_valid_o, mst_req_id_o);
        end
        tick();
        rst_n = 1'b0;
        mst_rsp_valid_i = 1'b1;
        mst_rsp_id_i = 4'b0110;
        #1;
        vectors++;
        if (rsp_valid_o !== 8'h00 || mst_rsp_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_stale_rsp got v %h rdy %b want 00 1", rsp_valid_o, mst_rsp_ready_o);
        end
        tick();
        mst_rsp_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_back_to_back();
        test_outstanding();
        test_rsp_routing();
        test_invalid_rsp();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/acc_req_rr_arbiter.md
Name: acc_req_rr_arbiter

Overview:
- Shares one accelerator C-bus slave port among NumReq requesters: round-robin request arbitration, requester-index ID extension, and ID-based response routing.
- Per-requester outstanding-transaction limiting.
- Sits between core-side requester ports and the interconnect slave port of one hierarchy level.
- Its request output matches the ExtIdWidth = IdWidth + idx_width(NumReq) convention of the interconnect.

Parameters:
NumReq, 8, number of requester ports (>=2)
AddrWidth, 6, request address width (hier + acc address)
DataWidth, 32, operand/result width
IdWidth, 1, requester-side ID width
MaxOutstanding, 4, max un-responded requests per requester (>=1)
ExtIdWidth, IdWidth+$clog2(NumReq), derived, not overridable; extended ID width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-high
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester request accept
req_addr_i  in  NumReq*AddrWidth  request addresses
req_data_i  in  NumReq*DataWidth  request operands
req_id_i  in  NumReq*IdWidth  requester-local IDs
mst_req_valid_o  out  1  arbitrated request valid
mst_req_ready_i  in  1  downstream accept
mst_req_addr_o  out  AddrWidth  arbitrated address
mst_req_data_o  out  DataWidth  arbitrated operand
mst_req_id_o  out  ExtIdWidth  {requester index, local id}
mst_rsp_valid_i  in  1  downstream response valid
mst_rsp_ready_o  out  1  response accept
mst_rsp_data_i  in  DataWidth  response data
mst_rsp_id_i  in  ExtIdWidth  extended response ID
rsp_valid_o  out  NumReq  per-requester response valid
rsp_ready_i  in  NumReq  per-requester response accept
rsp_data_o  out  NumReq*DataWidth  response data, broadcast
rsp_id_o  out  NumReq*IdWidth  local ID, lower IdWidth bits of mst_rsp_id_i
rsp_err_o  out  1  one-cycle pulse on dropped invalid-index response

Behaviour:
- Reset:
  - rst_n=1 clears all state immediately, regardless of clk: output buffer empty (mst_req_valid_o=0), addr/data/id regs 0, RR pointer 0, all outstanding counters 0, rsp_err_o=0.
  - A transaction in flight at reset is discarded. Responses to it arriving after reset are treated as unmatched (see below).
- Eligibility: requester i is eligible when req_valid_i[i]=1 and cnt[i] < MaxOutstanding.
- Arbitration: round-robin over eligible requesters, starting at the RR pointer and scanning upward modulo NumReq.
- Grant condition: a grant occurs in a cycle when the buffer is empty, or the buffer is valid and mst_req_ready_i=1 (drain and refill in the same cycle).
- Grant effects:
  - req_ready_o[winner]=1 combinationally; all other bits 0.
  - Buffer loads {winner, id} on the next edge.
  - RR pointer <= (winner+1) mod NumReq.
  - No grant leaves the pointer unchanged.
- Latency and throughput: requester handshake at cycle N gives mst_req_valid_o=1 at cycle N+1. Sustained throughput is 1 request/cycle.
- Output stability: mst_req_* are held stable while mst_req_valid_o=1 and mst_req_ready_i=0.
- Outstanding counters (width $clog2(MaxOutstanding+1)):
  - Increment on requester-i handshake; decrement on response handshake routed to i.
  - Both in the same cycle: unchanged.
  - A counter never exceeds MaxOutstanding and never underflows.
- Response routing:
  - idx = mst_rsp_id_i[ExtIdWidth-1:IdWidth].
  - If idx < NumReq: rsp_valid_o[idx] = mst_rsp_valid_i, and mst_rsp_ready_o = rsp_ready_i[idx]. This path is combinational, zero latency.
  - If idx >= NumReq, or cnt[idx]==0 (unmatched): mst_rsp_ready_o=1, no rsp_valid_o asserted, rsp_err_o pulses 1 on the following cycle, and no counter changes.
- Requests and responses are independent; a response to requester i may complete in the same cycle i is granted again.

Test Plan:
1. Reset then idle → mst_req_valid_o=0, req_ready_o=0, rsp_err_o=0. Assert rst_n mid-transfer (buffer valid) → mst_req_valid_o drops to 0 asynchronously before the next edge.
2. Fairness: requesters 0, 3, 5 valid continuously, mst_req_ready_i=1, responses returned immediately → grant order 0,3,5,0,3,5. mst_req_id_o upper bits 0,3,5, lower bits equal req_id_i.
3. Backpressure: mst_req_ready_i=0 for 4 cycles with requester 2 granted → output held constant, no further req_ready_o pulses. On the ready edge, drain and refill occur in the same cycle.
4. Outstanding limit (MaxOutstanding=4, no responses): requester 1 sends 4 requests → 5th is blocked (req_ready_o[1]=0) while requester 6 is still granted. One response with id {1,x} → requester 1 is granted again.
5. Response routing: mst_rsp_id_i={4,1}, data 0xDEADBEEF, rsp_ready_i[4]=0 for 2 cycles → rsp_valid_o[4] held, mst_rsp_ready_o=0. Handshake completes when rsp_ready_i[4]=1; rsp_id_o for requester 4 = 1.
6. Invalid or unmatched response: idx=7 with cnt[7]=0 → mst_rsp_ready_o=1, all rsp_valid_o=0, rsp_err_o=1 for exactly 1 cycle. With NumReq=6, idx=7 → same behaviour.
